// File: rtl/wc_pkg.sv
// Shared constants and tile type for the Winograd F(3,3) datapath and its neighbours.
package wc_pkg;
  localparam int WC_DW   = 10;
  localparam int WC_M    = 3;
  localparam int WC_R    = 3;
  localparam int WC_TILE = WC_M + WC_R - 1;

  typedef logic [WC_TILE-1:0][WC_DW-1:0] wc_tile_t;
endpackage

// File: rtl/wc_out_reg.sv
// Single-entry valid/ready output register carrying a payload and a last flag.
module wc_out_reg
  import wc_pkg::*;
#(
  parameter int W = WC_TILE * WC_DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         o_free
);
  logic         r_valid;
  logic         r_last;
  logic [W-1:0] r_data;

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

  // Load wins over drain so a tile accepted in the same cycle is replaced seamlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_last  <= i_last;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end
endmodule

// File: rtl/wc_tile_loader.sv
// Turns a one-sample-per-beat row stream into overlapping, zero-padded input tiles
// for the Winograd F(3,3) core.
module wc_tile_loader
  import wc_pkg::*;
#(
  parameter int DW   = WC_DW,
  parameter int TILE = WC_TILE,
  parameter int STEP = WC_M
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [TILE*DW-1:0] m_tile,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready
);
  localparam int CW   = $clog2(TILE + 1);
  localparam int KEEP = TILE - STEP;

  logic [TILE-1:0][DW-1:0] r_win;
  logic [CW-1:0]           r_cnt;
  logic [TILE-1:0][DW-1:0] w_win_nxt;
  logic [TILE-1:0][DW-1:0] w_win_keep;
  logic [TILE-1:0][DW-1:0] w_tile;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    w_accept;
  logic                    w_full;
  logic                    w_emit;
  logic                    w_free;

  assign s_ready   = !rst && w_free;
  assign w_accept  = s_valid && s_ready;
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_full    = (w_cnt_nxt == CW'(TILE));
  assign w_emit    = w_accept && (s_last || w_full);

  // Window with the incoming sample placed, padded tile view, and the overlap kept after a full tile.
  always_comb begin
    w_win_nxt  = r_win;
    w_tile     = '0;
    w_win_keep = '0;
    for (int k = 0; k < TILE; k++) begin
      if (k == int'(r_cnt)) begin
        w_win_nxt[k] = s_data;
      end else begin
        w_win_nxt[k] = r_win[k];
      end
      if (k < int'(w_cnt_nxt)) begin
        w_tile[k] = w_win_nxt[k];
      end else begin
        w_tile[k] = '0;
      end
    end
    for (int j = 0; j < KEEP; j++) begin
      w_win_keep[j] = w_win_nxt[STEP + j];
    end
  end

  // Window and fill count; a row end always flushes so nothing leaks into the next row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (s_last) begin
        r_win <= '0;
        r_cnt <= '0;
      end else if (w_full) begin
        r_win <= w_win_keep;
        r_cnt <= CW'(KEEP);
      end else begin
        r_win <= w_win_nxt;
        r_cnt <= w_cnt_nxt;
      end
    end else begin
      r_win <= r_win;
      r_cnt <= r_cnt;
    end
  end

  wc_out_reg #(
    .W (TILE * DW)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_emit),
    .i_data  (w_tile),
    .i_last  (s_last),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_tile),
    .o_last  (m_last),
    .o_free  (w_free)
  );
endmodule

// File: tb/tb_wc_tile_loader.sv
// Self-checking bench for wc_tile_loader: vector table, hand sequences, random rows vs. a tile model.
module tb_wc_tile_loader;
  logic        clk;
  logic        rst;
  logic [9:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [49:0] m_tile;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;

  int checks = 0;
  int errors = 0;

  wc_tile_loader dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_tile  (m_tile),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [9:0]  d;
    logic        l;
    logic        mr;
    logic        ev;
    logic [49:0] et;
    logic        el;
  } vec_t;

  typedef struct packed {
    logic [49:0] t;
    logic        l;
  } exp_t;

  vec_t        tbl [32];
  int          ntbl = 0;
  exp_t        expq [$];
  int          cntq [$];
  logic [9:0]  rowbuf [40];
  int          len;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [49:0] mk5(input int a, input int b, input int c, input int d, input int e);
    return {e[9:0], d[9:0], c[9:0], b[9:0], a[9:0]};
  endfunction

  task automatic add(input logic v, input int d, input logic l, input logic ev, input logic [49:0] et, input logic el);
    tbl[ntbl].v  = v;
    tbl[ntbl].d  = d[9:0];
    tbl[ntbl].l  = l;
    tbl[ntbl].mr = 1'b1;
    tbl[ntbl].ev = ev;
    tbl[ntbl].et = et;
    tbl[ntbl].el = el;
    ntbl++;
  endtask

  // Model: tiles start every 3 samples; a row ends with the tile that reaches its last sample.
  task automatic start_row();
    int p;
    logic [49:0] t;
    len = $urandom_range(1, 40);
    for (int i = 0; i < len; i++) rowbuf[i] = 10'($urandom_range(0, 1023));
    p = 0;
    while (p + 5 < len) begin
      t = '0;
      for (int k = 0; k < 5; k++) t[k*10 +: 10] = rowbuf[p + k];
      expq.push_back('{t: t, l: 1'b0});
      p += 3;
    end
    t = '0;
    for (int k = 0; k < len - p; k++) t[k*10 +: 10] = rowbuf[p + k];
    expq.push_back('{t: t, l: 1'b1});
    cntq.push_back((len <= 5) ? 1 : 1 + (len - 5 + 2) / 3);
  endtask

  initial begin
    int   cyc;
    int   row;
    int   idx;
    int   rtiles;
    logic acc_s;
    exp_t e;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_tile", m_tile, 50'd0);
    chk("rst_s_ready", s_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Row 1..11, row 1..7 then 20..24, single-sample row 42.
    for (int i = 1; i <= 11; i++)
      add(1'b1, i, (i == 11), (i == 6) || (i == 9), (i == 6) ? mk5(1,2,3,4,5) : mk5(4,5,6,7,8), 1'b0);
    add(1'b0, 0, 1'b0, 1'b1, mk5(7,8,9,10,11), 1'b1);
    for (int i = 1; i <= 7; i++)
      add(1'b1, i, (i == 7), (i == 6), mk5(1,2,3,4,5), 1'b0);
    add(1'b1, 20, 1'b0, 1'b1, mk5(4,5,6,7,0), 1'b1);
    for (int i = 21; i <= 24; i++)
      add(1'b1, i, (i == 24), 1'b0, 50'd0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b1, mk5(20,21,22,23,24), 1'b1);
    add(1'b1, 42, 1'b1, 1'b0, 50'd0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b1, mk5(42,0,0,0,0), 1'b1);
    add(1'b0, 0, 1'b0, 1'b0, 50'd0, 1'b0);

    for (int i = 0; i < ntbl; i++) begin
      @(negedge clk);
      s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l; m_ready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].ev);
      chk($sformatf("vec%0d_s_ready", i), s_ready, 1'b1);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_m_tile", i), m_tile, tbl[i].et);
        chk($sformatf("vec%0d_m_last", i), m_last, tbl[i].el);
      end
    end

    // Backpressure: hold the first tile for 6 cycles while sample 6 waits.
    for (int v = 1; v <= 5; v++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 10'(v); s_last = 1'b0; m_ready = 1'b1;
    end
    @(negedge clk);
    s_data = 10'd6; m_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("bp_hold_valid", m_valid, 1'b1);
      chk("bp_hold_tile", m_tile, mk5(1,2,3,4,5));
      chk("bp_hold_s_ready", s_ready, 1'b0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    chk("bp_release_s_ready", s_ready, 1'b1);
    chk("bp_release_tile", m_tile, mk5(1,2,3,4,5));
    @(negedge clk);
    s_data = 10'd7;
    #1;
    chk("bp_drained", m_valid, 1'b0);
    @(negedge clk);
    s_data = 10'd8; s_last = 1'b1;
    #1;
    chk("bp_no_early_tile", m_valid, 1'b0);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    chk("bp_second_valid", m_valid, 1'b1);
    chk("bp_second_tile", m_tile, mk5(4,5,6,7,8));
    chk("bp_second_last", m_last, 1'b1);

    // Asynchronous reset in the middle of a row.
    for (int v = 1; v <= 3; v++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 10'(v); s_last = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_s_ready", s_ready, 1'b0);
    chk("arst_m_tile", m_tile, 50'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int v = 9; v <= 13; v++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 10'(v); s_last = (v == 13);
      #1;
      chk("arst_no_stale_tile", m_valid, 1'b0);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    chk("arst_tile_valid", m_valid, 1'b1);
    chk("arst_tile", m_tile, mk5(9,10,11,12,13));
    chk("arst_tile_last", m_last, 1'b1);
    @(negedge clk);
    #1;
    chk("arst_single_tile", m_valid, 1'b0);

    // Random rows with random valid/ready against the tile model.
    cyc = 0; row = 0; idx = 0; rtiles = 0; acc_s = 1'b0;
    expq.delete(); cntq.delete();
    start_row();
    while ((row < 1000 || expq.size() != 0) && cyc < 90000) begin
      @(negedge clk);
      if (acc_s) begin
        s_valid = 1'b0;
        idx++;
        if (idx == len) begin
          row++;
          idx = 0;
          if (row < 1000) start_row();
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      if (!s_valid && row < 1000 && $urandom_range(0, 3) != 0) begin
        s_valid = 1'b1; s_data = rowbuf[idx]; s_last = (idx == len - 1);
      end
      #1;
      acc_s = s_valid && s_ready;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_spurious_tile actual=%h required=none", m_tile);
        end else begin
          e = expq.pop_front();
          rtiles++;
          chk("rnd_tile", m_tile, e.t);
          chk("rnd_last", m_last, e.l);
          if (e.l) begin
            chk("rnd_tiles_per_row", rtiles, cntq.pop_front());
            rtiles = 0;
          end
        end
      end
      cyc++;
    end
    chk("rnd_finished_in_budget", (cyc < 90000), 1'b1);
    chk("rnd_all_rows_sent", row, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
